// File: rtl/fb_pkg.sv
// fb_pkg -- shared definitions for the VGA frame-buffer arbiter.
//   FB_ADDR_W / FB_DATA_W / FB_DEPTH : default geometry (28x28 canvas, 4-bit pixels)
//   fb_state_e                       : clear sequencer states
//   fb_gnt_t                         : one-hot grant bundle for the three ports
package fb_pkg;

   localparam int FB_ADDR_W = 10;
   localparam int FB_DATA_W = 4;
   localparam int FB_DEPTH  = 784;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } fb_state_e;

   typedef struct packed {
      logic vga;
      logic drw;
      logic dnn;
   } fb_gnt_t;

endpackage

// File: rtl/fb_clear_seq.sv
// fb_clear_seq -- canvas-clear sequencer.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   clear_i         : clear request, honoured only in IDLE
//   vga_req_i       : VGA owns the RAM this cycle; the clear stalls
//   busy_o          : clear in progress (registered)
//   wr_o            : issue a zero write to addr_o this cycle
//   addr_o          : current clear address
module fb_clear_seq
   import fb_pkg::*;
#(
   parameter int ADDR_W = FB_ADDR_W,
   parameter int DEPTH  = FB_DEPTH
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clear_i,
   input  logic              vga_req_i,
   output logic              busy_o,
   output logic              wr_o,
   output logic [ADDR_W-1:0] addr_o
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   fb_state_e         state_q;
   logic              busy_q;
   logic [ADDR_W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (clear_i) begin
                  state_q <= ST_CLEAR;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            ST_CLEAR: begin
               // Counter only advances on cycles where the write actually went out.
               if (!vga_req_i) begin
                  if (cnt_q == LAST) begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o = busy_q;
   assign wr_o   = busy_q & ~vga_req_i;
   assign addr_o = cnt_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter -- single-port frame-buffer arbiter.
//   iBusClk, iRst                 : clock, synchronous active-high reset
//   iVga*/oVga*                   : scan-out read port, always wins
//   iDrw*/oDrwGnt                 : pen-draw write port
//   iDnn*/oDnn*                   : DNN feature read port
//   iClear/oBusy                  : canvas clear pulse / clear in progress
//   oRam*/iRamRdata               : single-port sync RAM, 1-cycle read latency
// Grants are combinational; read data is valid the cycle after the grant.
// Addresses >= DEPTH never reach the RAM: reads return 0, writes are dropped.
// Build option: VGA_FB_ARB_RR_EN -- round-robin between draw and DNN
// (default: draw has fixed priority over DNN).
module vga_fb_arbiter
   import fb_pkg::*;
#(
   parameter int ADDR_W = FB_ADDR_W,
   parameter int DATA_W = FB_DATA_W,
   parameter int DEPTH  = FB_DEPTH
) (
   input  logic              iBusClk,
   input  logic              iRst,
   input  logic              iVgaReq,
   input  logic [ADDR_W-1:0] iVgaAddr,
   output logic              oVgaGnt,
   output logic [DATA_W-1:0] oVgaData,
   output logic              oVgaValid,
   input  logic              iDrwReq,
   input  logic [ADDR_W-1:0] iDrwAddr,
   input  logic [DATA_W-1:0] iDrwData,
   output logic              oDrwGnt,
   input  logic              iDnnReq,
   input  logic [ADDR_W-1:0] iDnnAddr,
   output logic              oDnnGnt,
   output logic [DATA_W-1:0] oDnnData,
   output logic              oDnnValid,
   input  logic              iClear,
   output logic              oBusy,
   output logic              oRamEn,
   output logic              oRamWe,
   output logic [ADDR_W-1:0] oRamAddr,
   output logic [DATA_W-1:0] oRamWdata,
   input  logic [DATA_W-1:0] iRamRdata
);

   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

   logic              clr_busy, clr_wr;
   logic [ADDR_W-1:0] clr_addr;

   fb_clear_seq #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_clear (
      .clk_i    (iBusClk),
      .rst_i    (iRst),
      .clear_i  (iClear),
      .vga_req_i(iVgaReq),
      .busy_o   (clr_busy),
      .wr_o     (clr_wr),
      .addr_o   (clr_addr)
   );

   fb_gnt_t           gnt;
   logic              drw_pick, dnn_pick;
   logic              rd_oob_d, rd_oob_q;
   logic              vga_vld_q, dnn_vld_q;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] vga_data_d, vga_data_q, dnn_data_d, dnn_data_q;

`ifdef VGA_FB_ARB_RR_EN
   logic rr_q;  // 0: draw has priority, 1: DNN has priority
   assign drw_pick = iDrwReq & (~iDnnReq | ~rr_q);
   assign dnn_pick = iDnnReq & ~drw_pick;
`else
   assign drw_pick = iDrwReq;
   assign dnn_pick = iDnnReq & ~iDrwReq;
`endif

   always_comb begin
      gnt       = '0;
      rd_oob_d  = 1'b0;
      oRamEn    = 1'b0;
      oRamWe    = 1'b0;
      oRamAddr  = '0;
      oRamWdata = '0;
      if (!iRst) begin
         if (iVgaReq) begin
            gnt.vga  = 1'b1;
            oRamAddr = iVgaAddr;
            oRamEn   = {1'b0, iVgaAddr} < DEPTH_X;
            rd_oob_d = ~oRamEn;
         end else if (clr_busy) begin
            // clr_wr is high here by construction (busy and VGA idle).
            oRamEn   = clr_wr;
            oRamWe   = clr_wr;
            oRamAddr = clr_addr;
         end else if (drw_pick) begin
            gnt.drw   = 1'b1;
            oRamAddr  = iDrwAddr;
            oRamWdata = iDrwData;
            oRamEn    = {1'b0, iDrwAddr} < DEPTH_X;
            oRamWe    = oRamEn;
         end else if (dnn_pick) begin
            gnt.dnn  = 1'b1;
            oRamAddr = iDnnAddr;
            oRamEn   = {1'b0, iDnnAddr} < DEPTH_X;
            rd_oob_d = ~oRamEn;
         end
      end
   end

   // Out-of-range reads never touched the RAM, so substitute zero for its stale output.
   assign rd_data    = rd_oob_q  ? '0 : iRamRdata;
   assign vga_data_d = vga_vld_q ? rd_data : vga_data_q;
   assign dnn_data_d = dnn_vld_q ? rd_data : dnn_data_q;

   always_ff @(posedge iBusClk) begin
      if (iRst) begin
         vga_vld_q  <= 1'b0;
         dnn_vld_q  <= 1'b0;
         rd_oob_q   <= 1'b0;
         vga_data_q <= '0;
         dnn_data_q <= '0;
`ifdef VGA_FB_ARB_RR_EN
         rr_q       <= 1'b0;
`endif
      end else begin
         vga_vld_q  <= gnt.vga;
         dnn_vld_q  <= gnt.dnn;
         rd_oob_q   <= rd_oob_d;
         vga_data_q <= vga_data_d;
         dnn_data_q <= dnn_data_d;
`ifdef VGA_FB_ARB_RR_EN
         if (gnt.drw | gnt.dnn) rr_q <= ~rr_q;
`endif
      end
   end

   assign oVgaGnt   = gnt.vga;
   assign oDrwGnt   = gnt.drw;
   assign oDnnGnt   = gnt.dnn;
   assign oVgaValid = vga_vld_q & ~iRst;
   assign oDnnValid = dnn_vld_q & ~iRst;
   assign oVgaData  = iRst ? '0 : vga_data_d;
   assign oDnnData  = iRst ? '0 : dnn_data_d;
   assign oBusy     = clr_busy & ~iRst;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

   logic       iBusClk = 1'b0;
   logic       iRst = 1'b1;
   logic       iVgaReq = 1'b0, iDrwReq = 1'b0, iDnnReq = 1'b0, iClear = 1'b0;
   logic [9:0] iVgaAddr = '0, iDrwAddr = '0, iDnnAddr = '0;
   logic [3:0] iDrwData = '0;
   logic       oVgaGnt, oVgaValid, oDrwGnt, oDnnGnt, oDnnValid, oBusy;
   logic       oRamEn, oRamWe;
   logic [9:0] oRamAddr;
   logic [3:0] oVgaData, oDnnData, oRamWdata;
   logic [3:0] ram_rdata = '0;
   logic [3:0] mem [0:1023] = '{default: '0};

   int pass_cnt = 0;
   int chk_cnt  = 0;

   always #5 iBusClk = ~iBusClk;

   vga_fb_arbiter dut (
      .iBusClk(iBusClk), .iRst(iRst),
      .iVgaReq(iVgaReq), .iVgaAddr(iVgaAddr), .oVgaGnt(oVgaGnt), .oVgaData(oVgaData), .oVgaValid(oVgaValid),
      .iDrwReq(iDrwReq), .iDrwAddr(iDrwAddr), .iDrwData(iDrwData), .oDrwGnt(oDrwGnt),
      .iDnnReq(iDnnReq), .iDnnAddr(iDnnAddr), .oDnnGnt(oDnnGnt), .oDnnData(oDnnData), .oDnnValid(oDnnValid),
      .iClear(iClear), .oBusy(oBusy),
      .oRamEn(oRamEn), .oRamWe(oRamWe), .oRamAddr(oRamAddr), .oRamWdata(oRamWdata), .iRamRdata(ram_rdata)
   );

   // Behavioural single-port RAM, 1-cycle read latency.
   always @(posedge iBusClk) begin
      if (oRamEn) begin
         if (oRamWe) mem[oRamAddr] <= oRamWdata;
         else        ram_rdata <= mem[oRamAddr];
      end
   end

   task automatic step();
      @(posedge iBusClk);
      #1;
   endtask

   task automatic idle();
      iVgaReq = 1'b0; iDrwReq = 1'b0; iDnnReq = 1'b0; iClear = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      iRst = 1'b1; iVgaReq = 1'b1; iVgaAddr = 10'd3;
      step(); step();
      @(negedge iBusClk);
      chk_cnt++; if (oVgaGnt !== 1'b0) $display("FAIL rst_vga_gnt got %b exp 0", oVgaGnt); else pass_cnt++;
      chk_cnt++; if ({oDrwGnt, oDnnGnt, oVgaValid, oDnnValid, oBusy} !== 5'b0) $display("FAIL rst_flags got %b exp 00000", {oDrwGnt, oDnnGnt, oVgaValid, oDnnValid, oBusy}); else pass_cnt++;
      chk_cnt++; if ({oRamEn, oRamWe, oRamAddr, oRamWdata} !== 16'h0) $display("FAIL rst_ram got %h exp 0", {oRamEn, oRamWe, oRamAddr, oRamWdata}); else pass_cnt++;
      chk_cnt++; if ({oVgaData, oDnnData} !== 8'h0) $display("FAIL rst_data got %h exp 00", {oVgaData, oDnnData}); else pass_cnt++;
      // Grant a VGA read, then reset: the pending valid must be dropped.
      step(); iRst = 1'b0;
      @(negedge iBusClk);
      chk_cnt++; if (oVgaGnt !== 1'b1) $display("FAIL rst_rel_vga_gnt got %b exp 1", oVgaGnt); else pass_cnt++;
      step(); iRst = 1'b1; iVgaReq = 1'b0;
      @(negedge iBusClk);
      chk_cnt++; if (oVgaValid !== 1'b0) $display("FAIL rst_drop_valid got %b exp 0", oVgaValid); else pass_cnt++;
      step(); iRst = 1'b0;
      @(negedge iBusClk);
      chk_cnt++; if (oVgaValid !== 1'b0) $display("FAIL rst_drop_valid2 got %b exp 0", oVgaValid); else pass_cnt++;
      step();
   endtask

   task automatic test_vga_priority();
      iVgaReq = 1'b1; iVgaAddr = 10'd5;
      iDrwReq = 1'b1; iDrwAddr = 10'd5; iDrwData = 4'd9;
      @(negedge iBusClk);
      chk_cnt++; if ({oVgaGnt, oDrwGnt} !== 2'b10) $display("FAIL prio_gnt got %b exp 10", {oVgaGnt, oDrwGnt}); else pass_cnt++;
      step(); iVgaReq = 1'b0;
      @(negedge iBusClk);
      chk_cnt++; if ({oDrwGnt, oRamEn, oRamWe, oRamAddr, oRamWdata} !== {3'b111, 10'd5, 4'd9}) $display("FAIL prio_draw got %h exp %h", {oDrwGnt, oRamEn, oRamWe, oRamAddr, oRamWdata}, {3'b111, 10'd5, 4'd9}); else pass_cnt++;
      chk_cnt++; if (oVgaValid !== 1'b1) $display("FAIL prio_vga_valid got %b exp 1", oVgaValid); else pass_cnt++;
      step(); iDrwReq = 1'b0; iVgaReq = 1'b1;
      step(); iVgaReq = 1'b0;
      @(negedge iBusClk);
      chk_cnt++; if ({oVgaValid, oVgaData} !== {1'b1, 4'd9}) $display("FAIL prio_readback got %h exp 19", {oVgaValid, oVgaData}); else pass_cnt++;
      step();
      @(negedge iBusClk);
      chk_cnt++; if ({oVgaValid, oVgaData} !== {1'b0, 4'd9}) $display("FAIL prio_hold got %h exp 09", {oVgaValid, oVgaData}); else pass_cnt++;
      step();
   endtask

   task automatic test_arbitration();
      logic [3:0] got;
      int         bad_dnn_vld;
      iRst = 1'b1; step(); iRst = 1'b0;
      iDrwReq = 1'b1; iDrwAddr = 10'd10; iDrwData = 4'd3;
      iDnnReq = 1'b1; iDnnAddr = 10'd10;
      got = '0; bad_dnn_vld = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge iBusClk);
         got[3-i] = oDrwGnt;
         if (oDrwGnt === oDnnGnt) bad_dnn_vld++;
         step();
      end
`ifdef VGA_FB_ARB_RR_EN
      chk_cnt++; if (got !== 4'b1010) $display("FAIL rr_order got %b exp 1010", got); else pass_cnt++;
      chk_cnt++; if (bad_dnn_vld !== 0) $display("FAIL rr_onehot got %0d exp 0", bad_dnn_vld); else pass_cnt++;
      iDrwReq = 1'b0; iDnnReq = 1'b0;
      @(negedge iBusClk);
      chk_cnt++; if ({oDnnValid, oDnnData} !== {1'b1, 4'd3}) $display("FAIL rr_dnn_data got %h exp 13", {oDnnValid, oDnnData}); else pass_cnt++;
`else
      chk_cnt++; if (got !== 4'b1111) $display("FAIL fixed_order got %b exp 1111", got); else pass_cnt++;
      chk_cnt++; if (bad_dnn_vld !== 0) $display("FAIL fixed_onehot got %0d exp 0", bad_dnn_vld); else pass_cnt++;
      iDrwReq = 1'b0;
      @(negedge iBusClk);
      chk_cnt++; if ({oDnnGnt, oDnnValid} !== 2'b10) $display("FAIL fixed_dnn_alone got %b exp 10", {oDnnGnt, oDnnValid}); else pass_cnt++;
      iDnnReq = 1'b0;
`endif
      step();
   endtask

   task automatic test_clear();
      int busy_n, wr_n, bad, exp_a;
      busy_n = 0; wr_n = 0; bad = 0; exp_a = 0;
      idle(); iClear = 1'b1;
      @(negedge iBusClk);
      chk_cnt++; if (oBusy !== 1'b0) $display("FAIL clr_busy_pre got %b exp 0", oBusy); else pass_cnt++;
      step(); iClear = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge iBusClk);
         if (oBusy === 1'b1) begin
            busy_n++;
            if (oRamEn === 1'b1 && oRamWe === 1'b1) begin
               if (oRamAddr !== 10'(exp_a) || oRamWdata !== 4'd0) bad++;
               exp_a++; wr_n++;
            end
         end else if (busy_n > 0) break;
         step();
      end
      chk_cnt++; if (busy_n !== 784) $display("FAIL clr_busy_cycles got %0d exp 784", busy_n); else pass_cnt++;
      chk_cnt++; if (wr_n !== 784) $display("FAIL clr_writes got %0d exp 784", wr_n); else pass_cnt++;
      chk_cnt++; if (bad !== 0) $display("FAIL clr_seq_errors got %0d exp 0", bad); else pass_cnt++;
      chk_cnt++; if (oRamEn !== 1'b0) $display("FAIL clr_idle_ram got %b exp 0", oRamEn); else pass_cnt++;
      step(); iVgaReq = 1'b1; iVgaAddr = 10'd5;
      step(); iVgaReq = 1'b0;
      @(negedge iBusClk);
      chk_cnt++; if ({oVgaValid, oVgaData} !== {1'b1, 4'd0}) $display("FAIL clr_readback got %h exp 10", {oVgaValid, oVgaData}); else pass_cnt++;
      step();
   endtask

   task automatic test_clear_vga();
      int  busy_n, bad, exp_a, drw_leak, vga_miss;
      logic ph;
      busy_n = 0; bad = 0; exp_a = 0; drw_leak = 0; vga_miss = 0; ph = 1'b1;
      idle(); iClear = 1'b1;
      iDrwReq = 1'b1; iDrwAddr = 10'd20; iDrwData = 4'd7;
      @(negedge iBusClk);
      chk_cnt++; if (oDrwGnt !== 1'b1) $display("FAIL clrv_coincident_gnt got %b exp 1", oDrwGnt); else pass_cnt++;
      step(); iClear = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         iVgaReq = ph; ph = ~ph;
         @(negedge iBusClk);
         if (oBusy === 1'b1) begin
            busy_n++;
            if (oDrwGnt !== 1'b0) drw_leak++;
            if (oVgaGnt !== iVgaReq) vga_miss++;
            if (oRamEn === 1'b1 && oRamWe === 1'b1) begin
               if (oRamAddr !== 10'(exp_a) || oRamWdata !== 4'd0) bad++;
               exp_a++;
            end
         end else if (busy_n > 0) break;
         step();
      end
      chk_cnt++; if (busy_n < 1567 || busy_n > 1569) $display("FAIL clrv_cycles got %0d exp 1568", busy_n); else pass_cnt++;
      chk_cnt++; if (exp_a !== 784) $display("FAIL clrv_writes got %0d exp 784", exp_a); else pass_cnt++;
      chk_cnt++; if (bad !== 0) $display("FAIL clrv_seq_errors got %0d exp 0", bad); else pass_cnt++;
      chk_cnt++; if (drw_leak !== 0) $display("FAIL clrv_draw_leak got %0d exp 0", drw_leak); else pass_cnt++;
      chk_cnt++; if (vga_miss !== 0) $display("FAIL clrv_vga_gnt got %0d exp 0", vga_miss); else pass_cnt++;
      step(); iVgaReq = 1'b0;
      @(negedge iBusClk);
      chk_cnt++; if ({oDrwGnt, oRamWe, oRamAddr} !== {2'b11, 10'd20}) $display("FAIL clrv_draw_after got %h exp %h", {oDrwGnt, oRamWe, oRamAddr}, {2'b11, 10'd20}); else pass_cnt++;
      step(); idle();
   endtask

   task automatic test_out_of_range();
      idle(); iDrwReq = 1'b1; iDrwAddr = 10'd30; iDrwData = 4'hA;
      step(); iDrwReq = 1'b0; iDnnReq = 1'b1; iDnnAddr = 10'd30;
      step(); iDnnAddr = 10'd800;
      @(negedge iBusClk);
      chk_cnt++; if ({oDnnValid, oDnnData} !== {1'b1, 4'hA}) $display("FAIL oob_inrange_read got %h exp 1a", {oDnnValid, oDnnData}); else pass_cnt++;
      chk_cnt++; if ({oDnnGnt, oRamEn} !== 2'b10) $display("FAIL oob_read_en got %b exp 10", {oDnnGnt, oRamEn}); else pass_cnt++;
      step(); iDnnReq = 1'b0;
      @(negedge iBusClk);
      chk_cnt++; if ({oDnnValid, oDnnData} !== {1'b1, 4'h0}) $display("FAIL oob_read_data got %h exp 10", {oDnnValid, oDnnData}); else pass_cnt++;
      iDrwReq = 1'b1; iDrwAddr = 10'd900; iDrwData = 4'd5;
      #1;
      chk_cnt++; if ({oDrwGnt, oRamEn, oRamWe} !== 3'b100) $display("FAIL oob_write_en got %b exp 100", {oDrwGnt, oRamEn, oRamWe}); else pass_cnt++;
      step(); iDrwAddr = 10'd783;
      @(negedge iBusClk);
      chk_cnt++; if ({oRamEn, oRamWe} !== 2'b11) $display("FAIL edge_783_en got %b exp 11", {oRamEn, oRamWe}); else pass_cnt++;
      step(); iDrwAddr = 10'd784;
      @(negedge iBusClk);
      chk_cnt++; if (oRamEn !== 1'b0) $display("FAIL edge_784_en got %b exp 0", oRamEn); else pass_cnt++;
      step(); idle();
      chk_cnt++; if (mem[900] !== 4'd0) $display("FAIL oob_mem900 got %h exp 0", mem[900]); else pass_cnt++;
   endtask

   task automatic test_reset_mid_clear();
      int seen;
      seen = 0;
      idle(); iClear = 1'b1;
      step(); iClear = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge iBusClk);
         if (oRamEn === 1'b1 && oRamWe === 1'b1 && oRamAddr === 10'd300) begin
            seen = 1;
            break;
         end
         step();
      end
      chk_cnt++; if (seen !== 1) $display("FAIL rstc_reach_300 got %0d exp 1", seen); else pass_cnt++;
      step(); iRst = 1'b1;
      @(negedge iBusClk);
      chk_cnt++; if ({oBusy, oRamEn, oRamWe, oRamAddr} !== 13'h0) $display("FAIL rstc_during got %h exp 0", {oBusy, oRamEn, oRamWe, oRamAddr}); else pass_cnt++;
      step(); iRst = 1'b0;
      @(negedge iBusClk);
      chk_cnt++; if ({oBusy, oRamEn, oVgaValid, oDnnValid} !== 4'h0) $display("FAIL rstc_after got %b exp 0000", {oBusy, oRamEn, oVgaValid, oDnnValid}); else pass_cnt++;
      chk_cnt++; if ({oVgaData, oDnnData} !== 8'h0) $display("FAIL rstc_data got %h exp 00", {oVgaData, oDnnData}); else pass_cnt++;
      step(); iDrwReq = 1'b1; iDrwAddr = 10'd40; iDrwData = 4'd2;
      @(negedge iBusClk);
      chk_cnt++; if ({oDrwGnt, oRamEn, oRamWe, oRamAddr, oRamWdata} !== {3'b111, 10'd40, 4'd2}) $display("FAIL rstc_draw got %h exp %h", {oDrwGnt, oRamEn, oRamWe, oRamAddr, oRamWdata}, {3'b111, 10'd40, 4'd2}); else pass_cnt++;
      step(); idle(); step();
      @(negedge iBusClk);
      chk_cnt++; if (oBusy !== 1'b0) $display("FAIL rstc_no_resume got %b exp 0", oBusy); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_vga_priority();
      test_arbitration();
      test_clear();
      test_clear_vga();
      test_out_of_range();
      test_reset_mid_clear();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
